// File: rtl/mux2x1_pkg.sv
// ---------------------------------------------------------------------------
// mux2x1_pkg
//   Shared constants for the mux2x1_reg leaf select element.
//   - DEF_WIDTH / DEF_CNT_W : default data width and toggle-counter width
//   - SEL_D0 / SEL_D1       : select encoding (s=0 picks d0, s=1 picks d1)
//   Optional build macro used by the top: MUX2X1_PARITY_EN
// ---------------------------------------------------------------------------
package mux2x1_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 8;

    localparam logic SEL_D0 = 1'b0;
    localparam logic SEL_D1 = 1'b1;

endpackage : mux2x1_pkg

// File: rtl/mux2x1_comb.sv
// ---------------------------------------------------------------------------
// mux2x1_comb
//   Pure combinational WIDTH-wide 2:1 select, y = s ? d1 : d0.
//   Ports:
//     d0  in  [WIDTH-1:0]  data picked when s == SEL_D0
//     d1  in  [WIDTH-1:0]  data picked when s == SEL_D1
//     s   in  1            select
//     y   out [WIDTH-1:0]  selected data
// ---------------------------------------------------------------------------
module mux2x1_comb
    import mux2x1_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    // Plain conditional operator: an X/Z select merges d0/d1 bitwise,
    // which is the expected simulation behaviour for a leaf mux.
    assign y = (s == SEL_D1) ? d1 : d0;

endmodule : mux2x1_comb

// File: rtl/mux2x1_reg.sv
// ---------------------------------------------------------------------------
// mux2x1_reg
//   2:1 data mux with a combinational output, a registered output with a
//   valid qualifier, and a saturating count of accepted select changes.
//   Optional build macro: MUX2X1_PARITY_EN (adds registered parity y_par).
//
//   Ports:
//     clk        in   1        rising-edge clock
//     rst        in   1        synchronous active-high reset
//     d0         in   WIDTH    data selected when s=0
//     d1         in   WIDTH    data selected when s=1
//     s          in   1        select
//     in_valid   in   1        qualifies d0/d1/s for registration
//     y          out  WIDTH    combinational mux output
//     y_q        out  WIDTH    registered mux output (1-cycle latency)
//     out_valid  out  1        y_q was captured on the previous valid cycle
//     sel_q      out  1        last captured select value
//     tog_cnt    out  CNT_W    saturating count of accepted select changes
//     y_par      out  1        (MUX2X1_PARITY_EN only) XOR reduction of y_q
// ---------------------------------------------------------------------------
module mux2x1_reg
    import mux2x1_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid,
    output logic             sel_q,
`ifdef MUX2X1_PARITY_EN
    output logic [CNT_W-1:0] tog_cnt,
    output logic             y_par
`else
    output logic [CNT_W-1:0] tog_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] y_sel;
    logic             sel_chg;

    // Single mux instance; the register path captures its output so y and
    // y_q can never disagree on the selection rule.
    mux2x1_comb #(.WIDTH(WIDTH)) u_comb (
        .d0 (d0),
        .d1 (d1),
        .s  (s),
        .y  (y_sel)
    );

    assign y = y_sel;

    // A change only counts against a previously captured select; out_valid
    // gates the first sample after reset or after an idle gap where sel_q
    // is the reset value or stale.
    assign sel_chg = out_valid && (s != sel_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            out_valid <= 1'b0;
            sel_q     <= SEL_D0;
            tog_cnt   <= '0;
        end else if (in_valid) begin
            y_q       <= y_sel;
            out_valid <= 1'b1;
            sel_q     <= s;
            if (sel_chg && (tog_cnt != CNT_MAX))
                tog_cnt <= tog_cnt + CNT_W'(1);
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX2X1_PARITY_EN
    // Parity of the value being captured, so y_par always matches y_q.
    always_ff @(posedge clk) begin
        if (rst)
            y_par <= 1'b0;
        else if (in_valid)
            y_par <= ^y_sel;
    end
`endif

endmodule : mux2x1_reg

// File: tb/tb_mux2x1_reg.sv
// ---------------------------------------------------------------------------
// tb_mux2x1_reg
//   Two instances share clk/rst/s/in_valid: a WIDTH=1, CNT_W=2 instance
//   (truth table, counter saturation) and a WIDTH=8, CNT_W=8 instance.
//   A spec-level model is compared every negedge; directed literal checks
//   pin the model at key points.
// ---------------------------------------------------------------------------
module tb_mux2x1_reg;

    localparam int WA = 1;
    localparam int CA = 2;
    localparam int WB = 8;
    localparam int CB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s = 1'b0;
    logic          in_valid = 1'b0;
    logic [WA-1:0] d0a = '0, d1a = '0;
    logic [WB-1:0] d0b = '0, d1b = '0;

    logic [WA-1:0] ya, yqa;
    logic [WB-1:0] yb, yqb;
    logic          ova, ovb, sela, selb;
    logic [CA-1:0] toga;
    logic [CB-1:0] togb;
`ifdef MUX2X1_PARITY_EN
    logic          pa, pb;
`endif

    always #5 clk = ~clk;

    mux2x1_reg #(.WIDTH(WA), .CNT_W(CA)) dut_a (
        .clk(clk), .rst(rst), .d0(d0a), .d1(d1a), .s(s), .in_valid(in_valid),
        .y(ya), .y_q(yqa), .out_valid(ova), .sel_q(sela),
`ifdef MUX2X1_PARITY_EN
        .tog_cnt(toga), .y_par(pa)
`else
        .tog_cnt(toga)
`endif
    );

    mux2x1_reg #(.WIDTH(WB), .CNT_W(CB)) dut_b (
        .clk(clk), .rst(rst), .d0(d0b), .d1(d1b), .s(s), .in_valid(in_valid),
        .y(yb), .y_q(yqb), .out_valid(ovb), .sel_q(selb),
`ifdef MUX2X1_PARITY_EN
        .tog_cnt(togb), .y_par(pb)
`else
        .tog_cnt(togb)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Registered outputs are "the last accepted sample"; the toggle count is
    // kept unbounded and clipped to each instance's counter range on compare.
    logic          m_known = 1'b0;
    logic [WA-1:0] m_yqa;
    logic [WB-1:0] m_yqb;
    logic          m_ov, m_sel;
    int            m_tog;

    always @(posedge clk) begin
        if (rst) begin
            m_known <= 1'b1;
            m_yqa   <= '0;
            m_yqb   <= '0;
            m_ov    <= 1'b0;
            m_sel   <= 1'b0;
            m_tog   <= 0;
        end else if (in_valid) begin
            m_yqa <= (d0a & {WA{~s}}) | (d1a & {WA{s}});
            m_yqb <= (d0b & {WB{~s}}) | (d1b & {WB{s}});
            m_ov  <= 1'b1;
            m_sel <= s;
            if (m_ov && (s != m_sel)) m_tog <= m_tog + 1;
        end else begin
            m_ov <= 1'b0;
        end
    end

    function automatic int clip(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    always @(negedge clk) begin
        chk("m_y_a", 32'(ya), 32'((d0a & {WA{~s}}) | (d1a & {WA{s}})));
        chk("m_y_b", 32'(yb), 32'((d0b & {WB{~s}}) | (d1b & {WB{s}})));
        if (m_known) begin
            chk("m_yq_a",  32'(yqa),  32'(m_yqa));
            chk("m_yq_b",  32'(yqb),  32'(m_yqb));
            chk("m_ov_a",  32'(ova),  32'(m_ov));
            chk("m_ov_b",  32'(ovb),  32'(m_ov));
            chk("m_sel_a", 32'(sela), 32'(m_sel));
            chk("m_sel_b", 32'(selb), 32'(m_sel));
            chk("m_tog_a", 32'(toga), 32'(clip(m_tog, CA)));
            chk("m_tog_b", 32'(togb), 32'(clip(m_tog, CB)));
`ifdef MUX2X1_PARITY_EN
            chk("m_par_a", 32'(pa), 32'(^m_yqa));
            chk("m_par_b", 32'(pb), 32'(^m_yqb));
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic r, input logic v, input logic ss,
                       input logic a0, input logic a1,
                       input logic [7:0] b0, input logic [7:0] b1);
        rst = r; in_valid = v; s = ss;
        d0a = a0; d1a = a1; d0b = b0; d1b = b1;
    endtask

    logic       tt_y   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       seq_s  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] seq_yq [5] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
    int         seq_ta [5] = '{0, 1, 2, 3, 3};
    int         seq_tb [5] = '{0, 1, 2, 3, 4};

    initial begin
        // reset held for two edges
        set(1, 0, 0, 0, 0, 8'h00, 8'h00);
        tick(); tick();
        chk("rst_yq_b",  32'(yqb),  32'h0);
        chk("rst_ov_b",  32'(ovb),  32'h0);
        chk("rst_sel_b", 32'(selb), 32'h0);
        chk("rst_tog_b", 32'(togb), 32'h0);
        chk("rst_yq_a",  32'(yqa),  32'h0);

        // WIDTH=1 truth table: {D0,D1,S} = 000..111
        for (int i = 0; i < 8; i++) begin
            set(0, 1, i[0], i[2], i[1], 8'hA5, 8'h3C);
            #1;
            chk("tt_y", 32'(ya), 32'(tt_y[i]));
            tick();
            chk("tt_yq", 32'(yqa), 32'(tt_y[i]));
            chk("tt_ov", 32'(ova), 32'h1);
        end

        // reset overrides a valid cycle
        set(1, 1, 1, 1, 0, 8'hA5, 8'hFF);
        tick();
        chk("rov_yq_b",  32'(yqb),  32'h0);
        chk("rov_ov_b",  32'(ovb),  32'h0);
        chk("rov_sel_b", 32'(selb), 32'h0);
        chk("rov_tog_b", 32'(togb), 32'h0);
        chk("rov_tog_a", 32'(toga), 32'h0);

        // five valid toggling cycles: CNT_W=2 saturates at 3
        for (int i = 0; i < 5; i++) begin
            set(0, 1, seq_s[i], 1, 0, 8'hA5, 8'h3C);
            tick();
            chk("seq_yq_b",  32'(yqb),  32'(seq_yq[i]));
            chk("seq_tog_a", 32'(toga), 32'(seq_ta[i]));
            chk("seq_tog_b", 32'(togb), 32'(seq_tb[i]));
            chk("seq_sel_b", 32'(selb), 32'(seq_s[i]));
        end
        set(0, 1, 1, 1, 0, 8'hA5, 8'h3C);
        tick();
        chk("sat_yq_b",  32'(yqb),  32'h3C);
        chk("sat_tog_a", 32'(toga), 32'h3);
        chk("sat_tog_b", 32'(togb), 32'h5);

        // two idle cycles: registers hold, y still follows s
        set(0, 0, 0, 1, 0, 8'hA5, 8'h3C);
        #1 chk("idle_y0", 32'(yb), 32'hA5);
        tick();
        chk("idle_yq0",  32'(yqb),  32'h3C);
        chk("idle_ov0",  32'(ovb),  32'h0);
        chk("idle_tog0", 32'(togb), 32'h5);
        set(0, 0, 1, 1, 0, 8'hA5, 8'h3C);
        #1 chk("idle_y1", 32'(yb), 32'h3C);
        tick();
        chk("idle_yq1",  32'(yqb),  32'h3C);
        chk("idle_ov1",  32'(ovb),  32'h0);
        chk("idle_tog1", 32'(togb), 32'h5);
        chk("idle_sel1", 32'(selb), 32'h1);

        // parity vectors (data path checked in every build)
        set(0, 1, 0, 1, 0, 8'h07, 8'h3C);
        tick();
        chk("par7_yq", 32'(yqb), 32'h07);
`ifdef MUX2X1_PARITY_EN
        chk("par7", 32'(pb), 32'h1);
`endif
        set(0, 1, 0, 1, 0, 8'h03, 8'h3C);
        tick();
        chk("par3_yq", 32'(yqb), 32'h03);
`ifdef MUX2X1_PARITY_EN
        chk("par3", 32'(pb), 32'h0);
`endif
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_mux2x1_reg
